iommu_iotlb: RTL and testbench
==============================

Name: iommu_iotlb

Overview:
- Fully-associative I/O translation lookaside buffer. Sits beside the IOMMU page-walk controller, on its TLB interface.
- Answers combinational lookups (hit, translated physical address) for the device virtual address the walker presents.
- Absorbs fills from the walker after successful page walks; software/driver side can invalidate entries.
- Keeps saturating hit/miss statistics counters.

Parameters:
- ENTRIES, 16, number of translation entries; power of two, 2..64
- CNT_W, 32, width of the hit and miss statistics counters

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- lookup_valid  input  1  walker is presenting a lookup this cycle
- lookup_vaddr  input  32  device virtual address to translate
- tlb_hit  output  1  matching valid entry found (combinational)
- tlb_paddr  output  32  {matched PPN, lookup_vaddr[11:0]}; 0 when no hit (combinational)
- tlb_update_valid  input  1  fill strobe from walker, one cycle
- tlb_update_vaddr  input  32  virtual address of fill; bits [31:12] used as VPN
- tlb_update_paddr  input  32  physical address of fill; bits [31:12] used as PPN
- inv_all  input  1  invalidate every entry
- inv_page  input  1  invalidate entry whose VPN equals inv_vaddr[31:12]
- inv_vaddr  input  32  address for inv_page
- hit_count  output  CNT_W  saturating count of lookups that hit
- miss_count  output  CNT_W  saturating count of lookups that missed
- valid_count  output  $clog2(ENTRIES)+1  number of valid entries

Behaviour:
- Storage per entry: valid bit, 20-bit VPN, 20-bit PPN. Page size is fixed at 4 KiB.
- Reset: all valid bits 0, replacement pointer 0, hit_count = miss_count = 0, valid_count = 0.
  - tlb_hit = 0 and tlb_paddr = 0 immediately after reset.
  - VPN/PPN storage contents are don't-care after reset.
- Lookup: purely combinational, zero latency.
  - tlb_hit = OR over entries of (valid & VPN == lookup_vaddr[31:12]), gated by lookup_valid.
  - tlb_paddr = {PPN of matched entry, lookup_vaddr[11:0]}.
  - At most one entry can ever match; the no-duplicate rule below guarantees this.
- Statistics: on each clock edge with lookup_valid = 1, increment hit_count if tlb_hit, else miss_count.
  - Counters saturate at all-ones; there is no wrap.
  - Counters clear only on reset.
- Fill (tlb_update_valid = 1), victim selection:
  - If the VPN already resides in a valid entry, overwrite that entry's PPN; the pointer does not move.
  - Else, if any entry is invalid, fill the lowest-index invalid entry; the pointer does not move.
  - Else, replace the entry at the replacement pointer, then increment the pointer modulo ENTRIES (wraps ENTRIES-1 -> 0).
  - The new entry is visible to lookups on the cycle after the fill edge.
- inv_all: clears all valid bits in one cycle. The pointer returns to 0.
- inv_page: clears the matching entry, if any; no effect on a miss. The pointer is unchanged.
- Simultaneous events, resolved in the same cycle:
  - inv_all together with a fill: inv_all wins and the fill is dropped.
  - inv_page together with a fill: the invalidate is applied first, then the fill. A fill of the same VPN therefore survives, installed in the freed slot.
  - inv_all together with inv_page: equivalent to inv_all.
  - A lookup in the same cycle as a fill or invalidate sees the pre-edge contents.
- valid_count: registered population count, updated with the same edge as valid-bit changes.
- Reset mid-operation: reset overrides every input in that cycle. No partial fill is retained.
- The block has no state machine beyond the pointer and valid array. All sequential state is the entry array, the pointer and the counters.

Decomposition:
- Shared package iommu_pkg:
  - PAGE_SHIFT = 12, VPN_W = 20, PPN_W = 20
  - Typedef iotlb_entry_t {valid, vpn, ppn}
  - The walker also imports iommu_pkg, so PAGE_SHIFT and field widths stay consistent.
- One natural sub-module: iotlb_victim_sel.
  - Inputs: valid vector, match vector, pointer.
  - Outputs: one-hot write-select.
  - Priority: match, then lowest invalid, then pointer.
  - Purely combinational, unit-testable in isolation.

Test Plan:
- Reset, then lookup 0x1234_5678 with lookup_valid = 1 -> tlb_hit = 0, tlb_paddr = 0, miss_count = 1, hit_count = 0.
- Fill vaddr 0x1234_5000 / paddr 0x0ABC_D000, then lookup 0x1234_5A7C -> tlb_hit = 1, tlb_paddr = 0x0ABC_DA7C, hit_count = 1, valid_count = 1.
- Fill 16 distinct VPNs 0x00000..0x0000F, then fill VPN 0x00010 -> entry 0 (VPN 0x00000) replaced, lookup 0x0000_0000 misses, pointer = 1. A further fill replaces entry 1.
- Refill an existing VPN 0x12345 with new PPN 0x0FFFF -> valid_count unchanged, lookup 0x1234_5004 returns 0x0FFF_F004.
- inv_page 0x1234_5000 in the same cycle as a fill of 0x1234_5000 -> 0x0000_1000 -> entry valid, lookup 0x1234_5010 returns 0x0000_1010. inv_all in the same cycle as any fill -> valid_count = 0 and the fill is absent.
- Force hit_count to all-ones minus 1 (CNT_W = 4 build: 14), perform 3 hitting lookups -> hit_count = 15, held. Assert reset during a fill -> all entries invalid, counters 0.

Source files
------------

// File: rtl/iommu_pkg.sv
// Shared IOMMU definitions: page geometry and the IOTLB entry layout.
// The page-walk controller imports this too, so field widths stay in step.
package iommu_pkg;

    localparam int PAGE_SHIFT = 12;
    localparam int VPN_W      = 20;
    localparam int PPN_W      = 20;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
    } iotlb_entry_t;

    // Page number of a 32-bit address (4 KiB pages).
    function automatic logic [VPN_W-1:0] page_num(input logic [31:0] addr);
        return addr[31:PAGE_SHIFT];
    endfunction

endpackage

// File: rtl/iotlb_victim_sel.sv
// Chooses which IOTLB slot a fill writes: an entry already holding the VPN,
// otherwise the lowest-index free slot, otherwise the round-robin pointer.
module iotlb_victim_sel #(
    parameter int  ENTRIES = 16,
    localparam int PTR_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] valid_vec,
    input  logic [ENTRIES-1:0] match_vec,
    input  logic [PTR_W-1:0]   ptr,
    output logic [ENTRIES-1:0] wr_sel
);

    // Priority select: match, then lowest invalid, then pointer.
    always_comb begin
        wr_sel = '0;
        if (|match_vec) begin
            // At most one entry ever holds a given VPN, so this is one-hot.
            wr_sel = match_vec;
        end else if (!(&valid_vec)) begin
            // Walk downward so the last hit is the lowest free index.
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (!valid_vec[i]) begin
                    wr_sel    = '0;
                    wr_sel[i] = 1'b1;
                end
            end
        end else begin
            wr_sel[ptr] = 1'b1;
        end
    end

endmodule

// File: rtl/iommu_iotlb.sv
// Fully-associative IOTLB beside the page-walk controller: combinational
// lookup, fills from the walker, page/global invalidation and saturating
// hit/miss statistics.
module iommu_iotlb
    import iommu_pkg::*;
#(
    parameter int  ENTRIES = 16,
    parameter int  CNT_W   = 32,
    localparam int PTR_W   = $clog2(ENTRIES),
    localparam int VC_W    = $clog2(ENTRIES) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lookup_valid,
    input  logic [31:0]      lookup_vaddr,
    output logic             tlb_hit,
    output logic [31:0]      tlb_paddr,
    input  logic             tlb_update_valid,
    input  logic [31:0]      tlb_update_vaddr,
    input  logic [31:0]      tlb_update_paddr,
    input  logic             inv_all,
    input  logic             inv_page,
    input  logic [31:0]      inv_vaddr,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [VC_W-1:0]  valid_count
);

    iotlb_entry_t entries_q [ENTRIES];
    iotlb_entry_t entries_d [ENTRIES];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;
    logic [VC_W-1:0]  valid_count_q, valid_count_d;

    logic [ENTRIES-1:0] valid_vec;
    logic [ENTRIES-1:0] lk_match;
    logic [ENTRIES-1:0] inv_match;
    logic [ENTRIES-1:0] valid_mid;
    logic [ENTRIES-1:0] fill_match;
    logic [ENTRIES-1:0] wr_sel;
    logic [PPN_W-1:0]   hit_ppn;
    logic               use_ptr;

    // Page offsets of fill/invalidate addresses carry no information here.
    logic unused_offsets;
    assign unused_offsets = ^{tlb_update_vaddr[PAGE_SHIFT-1:0],
                              tlb_update_paddr[PAGE_SHIFT-1:0],
                              inv_vaddr[PAGE_SHIFT-1:0]};

    // Per-entry compare vectors; the fill compare sees the array after the
    // same-cycle invalidate, so a freed slot is reused by the fill.
    always_comb begin
        hit_ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            valid_vec[i] = entries_q[i].valid;
            lk_match[i]  = entries_q[i].valid &&
                           (entries_q[i].vpn == page_num(lookup_vaddr));
            inv_match[i] = inv_page && entries_q[i].valid &&
                           (entries_q[i].vpn == page_num(inv_vaddr));
            valid_mid[i] = !inv_all && valid_vec[i] && !inv_match[i];
            fill_match[i] = valid_mid[i] &&
                            (entries_q[i].vpn == page_num(tlb_update_vaddr));
            if (lk_match[i]) begin
                hit_ppn = hit_ppn | entries_q[i].ppn;
            end
        end
        use_ptr   = !(|fill_match) && (&valid_mid);
        tlb_hit   = lookup_valid && (|lk_match);
        tlb_paddr = tlb_hit ? {hit_ppn, lookup_vaddr[PAGE_SHIFT-1:0]} : '0;
    end

    iotlb_victim_sel #(
        .ENTRIES(ENTRIES)
    ) u_victim_sel (
        .valid_vec(valid_mid),
        .match_vec(fill_match),
        .ptr      (ptr_q),
        .wr_sel   (wr_sel)
    );

    // Next-state for the entry array, pointer, statistics and population count.
    always_comb begin
        entries_d     = entries_q;
        ptr_d         = ptr_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        valid_count_d = '0;

        for (int i = 0; i < ENTRIES; i++) begin
            entries_d[i].valid = valid_mid[i];
        end

        if (inv_all) begin
            // Global invalidate drops any concurrent fill.
            ptr_d = '0;
        end else if (tlb_update_valid) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (wr_sel[i]) begin
                    entries_d[i].valid = 1'b1;
                    entries_d[i].vpn   = page_num(tlb_update_vaddr);
                    entries_d[i].ppn   = tlb_update_paddr[31:PAGE_SHIFT];
                end
            end
            // Pointer only advances when a live entry was evicted; the
            // index width is exactly log2(ENTRIES), so it wraps naturally.
            if (use_ptr) begin
                ptr_d = ptr_q + 1'b1;
            end
        end

        for (int i = 0; i < ENTRIES; i++) begin
            valid_count_d = valid_count_d + VC_W'(entries_d[i].valid);
        end

        if (lookup_valid) begin
            if (tlb_hit) begin
                if (!(&hit_count_q)) hit_count_d = hit_count_q + 1'b1;
            end else begin
                if (!(&miss_count_q)) miss_count_d = miss_count_q + 1'b1;
            end
        end
    end

    // State registers; VPN/PPN storage needs no reset, only the valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i].valid <= 1'b0;
            end
            ptr_q         <= '0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
            valid_count_q <= '0;
        end else begin
            entries_q     <= entries_d;
            ptr_q         <= ptr_d;
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
            valid_count_q <= valid_count_d;
        end
    end

    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;
    assign valid_count = valid_count_q;

endmodule

// File: tb/tb_iommu_iotlb.sv
// Directed bench for iommu_iotlb (16 entries, 4-bit counters so saturation
// is reachable). Drivers push hand-computed expectations; a negedge monitor
// pops and compares whenever a lookup or a status probe is presented.
module tb_iommu_iotlb;

    localparam int ENTRIES = 16;
    localparam int CNT_W   = 4;
    localparam int VC_W    = 5;
    localparam int ST_W    = 2 * CNT_W + VC_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             lookup_valid = 1'b0;
    logic [31:0]      lookup_vaddr = '0;
    logic             tlb_hit;
    logic [31:0]      tlb_paddr;
    logic             tlb_update_valid = 1'b0;
    logic [31:0]      tlb_update_vaddr = '0;
    logic [31:0]      tlb_update_paddr = '0;
    logic             inv_all = 1'b0;
    logic             inv_page = 1'b0;
    logic [31:0]      inv_vaddr = '0;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;
    logic [VC_W-1:0]  valid_count;

    // Bench-side strobe marking a cycle where the status outputs are probed.
    logic stat_chk = 1'b0;

    logic [32:0]     lk_q[$];
    logic [ST_W-1:0] st_q[$];
    logic [32:0]     lk_exp;
    logic [ST_W-1:0] st_exp;
    int n_vec = 0;
    int n_err = 0;

    iommu_iotlb #(
        .ENTRIES(ENTRIES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .lookup_valid    (lookup_valid),
        .lookup_vaddr    (lookup_vaddr),
        .tlb_hit         (tlb_hit),
        .tlb_paddr       (tlb_paddr),
        .tlb_update_valid(tlb_update_valid),
        .tlb_update_vaddr(tlb_update_vaddr),
        .tlb_update_paddr(tlb_update_paddr),
        .inv_all         (inv_all),
        .inv_page        (inv_page),
        .inv_vaddr       (inv_vaddr),
        .hit_count       (hit_count),
        .miss_count      (miss_count),
        .valid_count     (valid_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        lookup_valid     = 1'b0;
        lookup_vaddr     = '0;
        tlb_update_valid = 1'b0;
        tlb_update_vaddr = '0;
        tlb_update_paddr = '0;
        inv_all          = 1'b0;
        inv_page         = 1'b0;
        inv_vaddr        = '0;
        stat_chk         = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic lookup(input logic [31:0] a, input logic h, input logic [31:0] p);
        @(posedge clk); #1;
        clear_inputs();
        lookup_valid = 1'b1;
        lookup_vaddr = a;
        lk_q.push_back({h, p});
    endtask

    task automatic fill(input logic [31:0] va, input logic [31:0] pa);
        @(posedge clk); #1;
        clear_inputs();
        tlb_update_valid = 1'b1;
        tlb_update_vaddr = va;
        tlb_update_paddr = pa;
    endtask

    task automatic inv_op(input logic all, input logic page, input logic [31:0] iva,
                          input logic f, input logic [31:0] fva, input logic [31:0] fpa);
        @(posedge clk); #1;
        clear_inputs();
        inv_all          = all;
        inv_page         = page;
        inv_vaddr        = iva;
        tlb_update_valid = f;
        tlb_update_vaddr = fva;
        tlb_update_paddr = fpa;
    endtask

    // Probe counters; lookup_vaddr points at a likely-resident page while
    // lookup_valid is low, so tlb_hit/tlb_paddr must read as zero.
    task automatic status(input int h, input int m, input int v);
        @(posedge clk); #1;
        clear_inputs();
        stat_chk     = 1'b1;
        lookup_vaddr = 32'h0000_3000;
        st_q.push_back({CNT_W'(h), CNT_W'(m), VC_W'(v)});
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (lookup_valid) begin
                n_vec++;
                if (lk_q.size() == 0) begin
                    n_err++;
                    $display("FAIL lookup_unexpected vaddr=%h got hit=%0b paddr=%h", lookup_vaddr, tlb_hit, tlb_paddr);
                end else begin
                    lk_exp = lk_q.pop_front();
                    if ({tlb_hit, tlb_paddr} !== lk_exp) begin
                        n_err++;
                        $display("FAIL lookup vaddr=%h got hit=%0b paddr=%h want hit=%0b paddr=%h",
                                 lookup_vaddr, tlb_hit, tlb_paddr, lk_exp[32], lk_exp[31:0]);
                    end
                end
            end
            if (stat_chk) begin
                n_vec++;
                if (st_q.size() == 0) begin
                    n_err++;
                    $display("FAIL status_unexpected hits=%0d misses=%0d valid=%0d", hit_count, miss_count, valid_count);
                end else begin
                    st_exp = st_q.pop_front();
                    if ({hit_count, miss_count, valid_count} !== st_exp || tlb_hit !== 1'b0 || tlb_paddr !== 32'h0) begin
                        n_err++;
                        $display("FAIL status got hits=%0d misses=%0d valid=%0d hit=%0b paddr=%h want hits=%0d misses=%0d valid=%0d hit=0 paddr=0",
                                 hit_count, miss_count, valid_count, tlb_hit, tlb_paddr,
                                 st_exp[ST_W-1 -: CNT_W], st_exp[VC_W +: CNT_W], st_exp[VC_W-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, then a miss on an empty TLB.
        status(0, 0, 0);
        lookup(32'h1234_5678, 1'b0, 32'h0);
        status(0, 1, 0);

        // Basic fill and hit with offset splice.
        fill(32'h1234_5000, 32'h0ABC_D000);
        lookup(32'h1234_5A7C, 1'b1, 32'h0ABC_DA7C);
        status(1, 1, 1);

        // Refill of a resident VPN overwrites in place.
        fill(32'h1234_5000, 32'h0FFF_F000);
        status(1, 1, 1);
        lookup(32'h1234_5004, 1'b1, 32'h0FFF_F004);

        // inv_page with a fill of the same VPN: fill survives.
        inv_op(1'b0, 1'b1, 32'h1234_5000, 1'b1, 32'h1234_5000, 32'h0000_1000);
        status(2, 1, 1);
        lookup(32'h1234_5010, 1'b1, 32'h0000_1010);

        // inv_all + inv_page + fill: everything cleared, fill dropped.
        inv_op(1'b1, 1'b1, 32'h1234_5000, 1'b1, 32'h5555_5000, 32'h0000_0000);
        status(3, 1, 0);
        lookup(32'h5555_5000, 1'b0, 32'h0);
        lookup(32'h1234_5010, 1'b0, 32'h0);

        // Fill all 16 slots with VPN i -> PPN 0x100+i.
        for (int i = 0; i < ENTRIES; i++) begin
            fill(32'(i) << 12, (32'h100 + 32'(i)) << 12);
        end
        status(3, 3, 16);

        // Full: VPN 0x10 replaces slot 0, pointer moves to 1.
        fill(32'h0001_0000, 32'h0020_0000);
        lookup(32'h0000_0000, 1'b0, 32'h0);
        lookup(32'h0001_0ABC, 1'b1, 32'h0020_0ABC);
        lookup(32'h0000_1123, 1'b1, 32'h0010_1123);

        // Next replacement hits slot 1 (VPN 1).
        fill(32'h0001_1000, 32'h0021_1000);
        lookup(32'h0000_1000, 1'b0, 32'h0);
        lookup(32'h0001_1000, 1'b1, 32'h0021_1000);
        lookup(32'h0000_2000, 1'b1, 32'h0010_2000);
        status(7, 5, 16);

        // inv_page miss has no effect; a hit frees exactly one slot.
        inv_op(1'b0, 1'b1, 32'h7777_7000, 1'b0, 32'h0, 32'h0);
        status(7, 5, 16);
        inv_op(1'b0, 1'b1, 32'h0000_5000, 1'b0, 32'h0, 32'h0);
        status(7, 5, 15);
        lookup(32'h0000_5000, 1'b0, 32'h0);

        // Freed slot 5 is taken without moving the pointer; next eviction is slot 2.
        fill(32'h0002_0000, 32'h0022_0000);
        fill(32'h0002_1000, 32'h0022_1000);
        lookup(32'h0000_2000, 1'b0, 32'h0);
        lookup(32'h0000_3000, 1'b1, 32'h0010_3000);
        lookup(32'h0002_0000, 1'b1, 32'h0022_0000);
        lookup(32'h0002_1000, 1'b1, 32'h0022_1000);
        status(10, 7, 16);

        // Hit counter to 14, then 3 more hits saturate at 15.
        for (int i = 0; i < 4; i++) lookup(32'h0000_3ABC, 1'b1, 32'h0010_3ABC);
        status(14, 7, 16);
        for (int i = 0; i < 3; i++) lookup(32'h0000_F001, 1'b1, 32'h0010_F001);
        status(15, 7, 16);

        // Miss counter: 9 misses from 7 saturates at 15.
        for (int i = 0; i < 9; i++) lookup(32'h0000_2000, 1'b0, 32'h0);
        status(15, 15, 16);

        // Reset asserted during a fill clears everything.
        @(posedge clk); #1;
        clear_inputs();
        reset            = 1'b1;
        tlb_update_valid = 1'b1;
        tlb_update_vaddr = 32'h0000_3000;
        tlb_update_paddr = 32'h0099_9000;
        @(posedge clk); #1;
        clear_inputs();
        reset = 1'b0;
        status(0, 0, 0);
        lookup(32'h0000_3000, 1'b0, 32'h0);
        status(0, 1, 0);

        idle();
        idle();
        idle();

        if (lk_q.size() != 0 || st_q.size() != 0) begin
            $display("FAIL drain lookups_left=%0d status_left=%0d want 0 and 0", lk_q.size(), st_q.size());
            n_vec += lk_q.size() + st_q.size();
            n_err += lk_q.size() + st_q.size();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
